// File: rtl/delta_trig_pkg.sv
// Shared definitions for the delta trigger chain (delay stage and shaper).
package delta_trig_pkg;

    localparam int WW_DEF = 8;   // pulse-width setting width
    localparam int DW_DEF = 16;  // dead-time setting width
    localparam int CW_DEF = 32;  // accepted-trigger counter width
    localparam int LW_DEF = 16;  // lost-trigger counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } trig_state_t;

endpackage

// File: rtl/delta_trig_shaper_if.sv
// Control/status bundle between the trigger source/slow control and the shaper.
interface delta_trig_shaper_if
    import delta_trig_pkg::*;
#(
    parameter int WW = WW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int LW = LW_DEF
);
    logic          trig_in;
    logic [WW-1:0] width;
    logic [DW-1:0] deadtime;
    logic          enable;
    logic          veto;
    logic          cnt_clr;
    logic          trig_out;
    logic          busy;
    logic [CW-1:0] trig_cnt;
    logic [LW-1:0] lost_cnt;

    modport master (
        output trig_in, width, deadtime, enable, veto, cnt_clr,
        input  trig_out, busy, trig_cnt, lost_cnt
    );

    modport slave (
        input  trig_in, width, deadtime, enable, veto, cnt_clr,
        output trig_out, busy, trig_cnt, lost_cnt
    );
endinterface

// File: rtl/trig_edge_det.sv
// Registers the incoming trigger and flags its rising edge; a held-high
// input produces a single one-cycle rise.
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);
    logic sig_d;

    // previous-cycle copy of the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_d <= 1'b0;
        else     sig_d <= sig_in;
    end

    assign rise = sig_in & ~sig_d;
endmodule

// File: rtl/delta_trig_shaper.sv
// Shapes the delayed delta trigger into a fixed-width pulse followed by a
// dead time, with enable/veto gating and accepted/lost trigger counters.
//
// state | meaning
// IDLE  | waiting for an accepted trigger edge
// PULSE | trig_out high, counting down the latched width
// DEAD  | trig_out low, counting down the latched dead time
module delta_trig_shaper
    import delta_trig_pkg::*;
#(
    parameter int WW = WW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int LW = LW_DEF
) (
    input logic               clk,
    input logic               rst,
    delta_trig_shaper_if.slave bus
);
    localparam int TW = (WW > DW) ? WW : DW;

    trig_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] dead_q,  dead_d;
    logic          trig_out_q;
    logic          busy_q;
    logic [CW-1:0] trig_cnt_q;
    logic [LW-1:0] lost_cnt_q;

    logic          evt;
    logic          accept;
    logic          lost_evt;
    logic [WW-1:0] w_eff;

    trig_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (bus.trig_in),
        .rise   (evt)
    );

    assign w_eff    = (bus.width == '0) ? WW'(1) : bus.width;
    assign accept   = evt & (state_q == IDLE) & bus.enable & ~bus.veto;
    assign lost_evt = evt & bus.enable & ~accept;

    // next-state and timer reload; timers count down to zero inclusive
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dead_d  = dead_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PULSE;
                    timer_d = TW'(w_eff) - TW'(1);
                    dead_d  = bus.deadtime;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    if (dead_q != '0) begin
                        state_d = DEAD;
                        timer_d = TW'(dead_q) - TW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DEAD: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; outputs registered from the next state so trig_out
    // follows the accepting edge by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            dead_q     <= '0;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dead_q     <= dead_d;
            trig_out_q <= (state_d == PULSE);
            busy_q     <= (state_d != IDLE);
        end
    end

    // accepted-trigger counter, wraps; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              trig_cnt_q <= '0;
        else if (bus.cnt_clr) trig_cnt_q <= '0;
        else if (accept)      trig_cnt_q <= trig_cnt_q + CW'(1);
    end

    // lost-trigger counter, saturates at all-ones; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 lost_cnt_q <= '0;
        else if (bus.cnt_clr)                    lost_cnt_q <= '0;
        else if (lost_evt && (lost_cnt_q != '1)) lost_cnt_q <= lost_cnt_q + LW'(1);
    end

    assign bus.trig_out = trig_out_q;
    assign bus.busy     = busy_q;
    assign bus.trig_cnt = trig_cnt_q;
    assign bus.lost_cnt = lost_cnt_q;
endmodule
